fr_align: RTL and testbench

- Pre-add alignment stage of the floating MAC datapath; it is the inverse of the post-add normalizer.
- Takes two unpacked operands (sign, biased exponent, 24-bit significand with hidden bit) and orders them by magnitude.
- Right-shifts the smaller significand by the exponent difference, iteratively, up to STEP bits per cycle, and accumulates guard/round/sticky bits.
- Delivers the aligned pair plus the common exponent to the significand adder over a valid/ready handshake.

---
 rtl/fr_align.sv | 102 ++++++++++
 tb/tb_fr_align.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fr_align.sv
// fr_align: pre-add alignment stage of the floating MAC datapath.
// Orders two unpacked operands by magnitude and right-shifts the smaller
// significand by the exponent difference, STEP bits per cycle, folding lost
// bits into a sticky bit.
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   in_valid / in_ready          operand pair handshake
//   a_sign, a_exp, a_sig         operand A (hidden bit at a_sig[23])
//   b_sign, b_exp, b_sig         operand B (hidden bit at b_sig[23])
//   out_valid / out_ready        aligned result handshake
//   big_sign, small_sign         signs of the larger / smaller operand
//   big_sig                      {larger significand, 3'b000}
//   small_sig                    {aligned smaller significand, sticky}
//   common_exp                   exponent of the larger operand
//   swapped                      1 when B was the larger operand
module fr_align #(
  parameter int STEP = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        a_sign,
  input  logic [7:0]  a_exp,
  input  logic [23:0] a_sig,
  input  logic        b_sign,
  input  logic [7:0]  b_exp,
  input  logic [23:0] b_sig,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        big_sign,
  output logic        small_sign,
  output logic [26:0] big_sig,
  output logic [26:0] small_sig,
  output logic [7:0]  common_exp,
  output logic        swapped
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [4:0] STP = 5'(STEP);
  state_t      state;
  logic [4:0]  rem;
  logic [25:0] sr;
  logic        sticky;
  logic        a_big;
  logic [7:0]  diff;
  logic [4:0]  eff;
  logic [4:0]  s;
  logic [25:0] lost_mask;
  always_comb begin
    a_big     = a_exp > b_exp || (a_exp == b_exp && a_sig >= b_sig);
    diff      = a_big ? a_exp - b_exp : b_exp - a_exp;
    eff       = diff > 8'd26 ? 5'd26 : diff[4:0];
    s         = rem > STP ? STP : rem;
    // s never exceeds 26; at s = 26 the shift wraps to 0 and the mask becomes all ones
    lost_mask = (26'd1 << s) - 26'd1;
  end
  assign in_ready  = state == IDLE && !reset;
  assign small_sig = {sr, sticky};
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      rem        <= '0;
      sr         <= '0;
      sticky     <= 1'b0;
      big_sign   <= 1'b0;
      small_sign <= 1'b0;
      big_sig    <= '0;
      common_exp <= '0;
      swapped    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          big_sign   <= a_big ? a_sign : b_sign;
          small_sign <= a_big ? b_sign : a_sign;
          common_exp <= a_big ? a_exp : b_exp;
          big_sig    <= {a_big ? a_sig : b_sig, 3'b000};
          sr         <= {a_big ? b_sig : a_sig, 2'b00};
          sticky     <= 1'b0;
          swapped    <= !a_big;
          rem        <= eff;
          state      <= eff == 5'd0 ? DONE : SHIFT;
          out_valid  <= eff == 5'd0;
        end
        SHIFT: begin
          sr     <= sr >> s;
          sticky <= sticky | (|(sr & lost_mask));
          rem    <= rem - s;
          if (rem == s) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fr_align.sv
// tb_fr_align: directed bench for fr_align with a cycle-level reference model.
module tb_fr_align;
  localparam int STEP = 4;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        a_sign = 1'b0;
  logic        b_sign = 1'b0;
  logic [7:0]  a_exp = '0;
  logic [7:0]  b_exp = '0;
  logic [23:0] a_sig = '0;
  logic [23:0] b_sig = '0;
  logic        in_ready;
  logic        out_valid;
  logic        big_sign;
  logic        small_sign;
  logic [26:0] big_sig;
  logic [26:0] small_sig;
  logic [7:0]  common_exp;
  logic        swapped;
  int tests = 0;
  int fails = 0;
  fr_align #(.STEP(STEP)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .a_exp(a_exp), .a_sig(a_sig),
    .b_sign(b_sign), .b_exp(b_exp), .b_sig(b_sig),
    .out_valid(out_valid), .out_ready(out_ready),
    .big_sign(big_sign), .small_sign(small_sign),
    .big_sig(big_sig), .small_sig(small_sig),
    .common_exp(common_exp), .swapped(swapped)
  );
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask
  function automatic int eff_of(input int d);
    return d > 26 ? 26 : d;
  endfunction
  // Whole-shift view: the small significand with two guard bits, shifted by
  // eff in one go, with every lost bit ORed into sticky.
  function automatic logic [26:0] align(input logic [23:0] sig, input int d);
    longint v;
    longint k;
    logic   lost;
    int     e;
    e    = eff_of(d);
    v    = longint'(sig) << 2;
    k    = v >> e;
    lost = (v & ((longint'(1) << e) - 1)) != 0;
    return {k[25:0], lost};
  endfunction
  function automatic int lat_of(input int d);
    return (eff_of(d) + STEP - 1) / STEP;
  endfunction
  // Model phases: 0 accepting, 1 counting down alignment cycles, 2 presenting result.
  int          m_st;
  int          m_cnt;
  logic        m_bs;
  logic        m_ss;
  logic        m_sw;
  logic [7:0]  m_exp;
  logic [26:0] m_big;
  logic [26:0] m_small;
  logic        ab;
  int          dd;
  assign ab = a_exp > b_exp || (a_exp == b_exp && a_sig >= b_sig);
  assign dd = ab ? int'(a_exp) - int'(b_exp) : int'(b_exp) - int'(a_exp);
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_st    <= 0;
      m_cnt   <= 0;
      m_bs    <= 1'b0;
      m_ss    <= 1'b0;
      m_sw    <= 1'b0;
      m_exp   <= '0;
      m_big   <= '0;
      m_small <= '0;
    end else if (m_st == 0) begin
      if (in_valid) begin
        m_bs    <= ab ? a_sign : b_sign;
        m_ss    <= ab ? b_sign : a_sign;
        m_sw    <= !ab;
        m_exp   <= ab ? a_exp : b_exp;
        m_big   <= {ab ? a_sig : b_sig, 3'b000};
        m_small <= align(ab ? b_sig : a_sig, dd);
        m_cnt   <= lat_of(dd);
        m_st    <= lat_of(dd) == 0 ? 2 : 1;
      end
    end else if (m_st == 1) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_st <= 2;
    end else if (out_ready) begin
      m_st <= 0;
    end
  end
  always @(negedge clock) begin
    if (reset) begin
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd0);
      chk("rst big_sig", 32'(big_sig), 32'd0);
      chk("rst small_sig", 32'(small_sig), 32'd0);
      chk("rst common_exp", 32'(common_exp), 32'd0);
    end else begin
      chk("cyc in_ready", 32'(in_ready), 32'(m_st == 0));
      chk("cyc out_valid", 32'(out_valid), 32'(m_st == 2));
      if (m_st == 2) begin
        chk("cyc big_sig", 32'(big_sig), 32'(m_big));
        chk("cyc small_sig", 32'(small_sig), 32'(m_small));
        chk("cyc common_exp", 32'(common_exp), 32'(m_exp));
        chk("cyc swapped", 32'(swapped), 32'(m_sw));
        chk("cyc big_sign", 32'(big_sign), 32'(m_bs));
        chk("cyc small_sign", 32'(small_sign), 32'(m_ss));
      end
    end
  end
  task automatic drive(input logic as_, input logic [7:0] ae, input logic [23:0] asg,
                       input logic bs_, input logic [7:0] be, input logic [23:0] bsg);
    a_sign = as_; a_exp = ae; a_sig = asg;
    b_sign = bs_; b_exp = be; b_sig = bsg;
    in_valid = 1'b1;
    @(posedge clock);
    #2;
    in_valid = 1'b0;
    a_sig = 24'h5A5A5A;
    b_sig = 24'hA5A5A5;
  endtask
  task automatic run(input string n,
                     input logic as_, input logic [7:0] ae, input logic [23:0] asg,
                     input logic bs_, input logic [7:0] be, input logic [23:0] bsg,
                     input logic [26:0] xb, input logic [26:0] xs, input logic xsw,
                     input logic [7:0] xe, input logic xbs, input logic xss,
                     input int lat, input int hold);
    int k;
    k = 0;
    drive(as_, ae, asg, bs_, be, bsg);
    while (k < 50) begin
      @(negedge clock);
      if (out_valid) break;
      @(posedge clock);
      k++;
    end
    chk({n, " latency"}, 32'(k), 32'(lat));
    chk({n, " big_sig"}, 32'(big_sig), 32'(xb));
    chk({n, " small_sig"}, 32'(small_sig), 32'(xs));
    chk({n, " swapped"}, 32'(swapped), 32'(xsw));
    chk({n, " common_exp"}, 32'(common_exp), 32'(xe));
    chk({n, " big_sign"}, 32'(big_sign), 32'(xbs));
    chk({n, " small_sign"}, 32'(small_sign), 32'(xss));
    repeat (hold) begin
      @(posedge clock);
      #2;
      in_valid = 1'b1;
      a_exp = 8'd200;
      b_exp = 8'd1;
      @(negedge clock);
      chk({n, " hold small_sig"}, 32'(small_sig), 32'(xs));
      chk({n, " hold big_sig"}, 32'(big_sig), 32'(xb));
      chk({n, " hold in_ready"}, 32'(in_ready), 32'd0);
      chk({n, " hold out_valid"}, 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #2;
    out_ready = 1'b0;
    @(negedge clock);
    chk({n, " release in_ready"}, 32'(in_ready), 32'd1);
    chk({n, " release out_valid"}, 32'(out_valid), 32'd0);
    @(posedge clock);
    #2;
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    @(negedge clock);
    chk("post-reset in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #2;
    run("basic", 1'b0, 8'd130, 24'h800000, 1'b1, 8'd127, 24'hC00000,
        27'h4000000, 27'h0C00000, 1'b0, 8'd130, 1'b0, 1'b1, 1, 0);
    run("eqswap", 1'b1, 8'd100, 24'h900000, 1'b0, 8'd100, 24'hA00000,
        27'h5000000, 27'h4800000, 1'b1, 8'd100, 1'b0, 1'b1, 0, 0);
    run("tie", 1'b1, 8'd50, 24'hABCDEF, 1'b0, 8'd50, 24'hABCDEF,
        27'h55E6F78, 27'h55E6F78, 1'b0, 8'd50, 1'b1, 1'b0, 0, 0);
    run("flush30", 1'b0, 8'd160, 24'h800000, 1'b0, 8'd130, 24'h800001,
        27'h4000000, 27'h0000001, 1'b0, 8'd160, 1'b0, 1'b0, 7, 10);
    run("flush26", 1'b0, 8'd156, 24'h800000, 1'b0, 8'd130, 24'h800001,
        27'h4000000, 27'h0000001, 1'b0, 8'd156, 1'b0, 1'b0, 7, 0);
    run("flush255", 1'b0, 8'd255, 24'h800000, 1'b0, 8'd0, 24'h800001,
        27'h4000000, 27'h0000001, 1'b0, 8'd255, 1'b0, 1'b0, 7, 0);
    run("partial5", 1'b0, 8'd105, 24'hFFFFFF, 1'b1, 8'd100, 24'h800003,
        27'h7FFFFF8, 27'h0200001, 1'b0, 8'd105, 1'b0, 1'b1, 2, 0);
    run("bbig4", 1'b0, 8'd10, 24'hFFFFFF, 1'b1, 8'd14, 24'h800000,
        27'h4000000, 27'h07FFFFF, 1'b1, 8'd14, 1'b1, 1'b0, 1, 3);
    // Reset during the third alignment cycle of a diff = 20 pair.
    drive(1'b0, 8'd147, 24'h800000, 1'b0, 8'd127, 24'hFFFFFF);
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("midshift out_valid", 32'(out_valid), 32'd0);
    chk("midshift big_sig", 32'(big_sig), 32'd0);
    chk("midshift small_sig", 32'(small_sig), 32'd0);
    chk("midshift common_exp", 32'(common_exp), 32'd0);
    chk("midshift in_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    @(negedge clock);
    chk("after rst in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #2;
    run("diff20", 1'b0, 8'd147, 24'h800000, 1'b0, 8'd127, 24'hFFFFFF,
        27'h4000000, 27'h000007F, 1'b0, 8'd147, 1'b0, 1'b0, 5, 0);
    // Reset while a result is being presented.
    drive(1'b0, 8'd130, 24'h800000, 1'b1, 8'd127, 24'hC00000);
    @(posedge clock);
    #2;
    chk("done out_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst-done out_valid", 32'(out_valid), 32'd0);
    chk("rst-done swapped", 32'(swapped), 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #2;
    run("again", 1'b0, 8'd130, 24'h800000, 1'b1, 8'd127, 24'hC00000,
        27'h4000000, 27'h0C00000, 1'b0, 8'd130, 1'b0, 1'b1, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
